// File: rtl/queue_pkg.sv
// Shared sizing and types for the two-entry valid/ready queue.
// Pointers carry one extra wrap bit above the slot index.
package queue_pkg;

    localparam int unsigned DATA_WIDTH = 4;
    localparam int unsigned DEPTH      = 2;
    localparam int unsigned IDX_W      = $clog2(DEPTH);
    localparam int unsigned PTR_W      = IDX_W + 1;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [IDX_W-1:0]      idx_t;
    typedef logic [PTR_W-1:0]      ptr_t;

endpackage

// File: rtl/queue_mem.sv
// Register-file storage for queue_wrapper: one synchronous write port,
// one asynchronous read port, cleared to zero on reset.
module queue_mem
    import queue_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_we,
    input  idx_t  i_waddr,
    input  data_t i_wdata,
    input  idx_t  i_raddr,
    output data_t o_rdata
);

    data_t [DEPTH-1:0] r_mem;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/queue_wrapper.sv
// Two-entry synchronous FIFO with valid/ready handshakes on both sides.
// Optional build macro QUEUE_DOUT_MASK_EN forces dout to zero while empty.
module queue_wrapper
    import queue_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  enq,
    input  data_t din,
    input  logic  deq,
    output logic  enq_ready,
    output logic  deq_valid,
    output data_t dout
);

    ptr_t  r_rd_ptr;
    ptr_t  r_wr_ptr;
    logic  w_empty;
    logic  w_full;
    logic  w_do_enq;
    logic  w_do_deq;
    data_t w_rdata;

    // Same slot index with opposite wrap bits means the writer lapped the reader.
    assign w_empty  = (r_rd_ptr == r_wr_ptr);
    assign w_full   = (r_rd_ptr[IDX_W-1:0] == r_wr_ptr[IDX_W-1:0]) &&
                      (r_rd_ptr[PTR_W-1] != r_wr_ptr[PTR_W-1]);
    assign w_do_enq = enq && !w_full;
    assign w_do_deq = deq && !w_empty;

    assign enq_ready = !w_full;
    assign deq_valid = !w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_do_enq) begin
                r_wr_ptr <= r_wr_ptr + ptr_t'(1);
            end
            if (w_do_deq) begin
                r_rd_ptr <= r_rd_ptr + ptr_t'(1);
            end
        end
    end

    queue_mem u_mem (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_we    (w_do_enq),
        .i_waddr (r_wr_ptr[IDX_W-1:0]),
        .i_wdata (din),
        .i_raddr (r_rd_ptr[IDX_W-1:0]),
        .o_rdata (w_rdata)
    );

`ifdef QUEUE_DOUT_MASK_EN
    assign dout = w_empty ? '0 : w_rdata;
`else
    assign dout = w_rdata;
`endif

endmodule

// File: tb/tb_queue_wrapper.sv
// Self-checking bench for queue_wrapper: directed vector table followed by
// randomized traffic compared against a queue-based reference model.
module tb_queue_wrapper;
    import queue_pkg::*;

    logic  clk;
    logic  rst;
    logic  enq;
    data_t din;
    logic  deq;
    logic  enq_ready;
    logic  deq_valid;
    data_t dout;

    int checks;
    int failures;

    queue_wrapper dut (
        .clk       (clk),
        .rst       (rst),
        .enq       (enq),
        .din       (din),
        .deq       (deq),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .dout      (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit       enq;
        bit [3:0] din;
        bit       deq;
        bit       exp_ready;
        bit       exp_valid;
        bit [3:0] exp_dout;
    } vec_t;

    vec_t vecs[$];

    localparam int D = int'(DEPTH);

    // Value shown on dout when empty: stale slot content, or zero when masked.
    function automatic bit [3:0] stale(input bit [3:0] v);
`ifdef QUEUE_DOUT_MASK_EN
        return 4'd0;
`else
        return v;
`endif
    endfunction

    task automatic add(input bit r, input bit e, input bit [3:0] d, input bit q,
                       input bit er, input bit dv, input bit [3:0] dout_exp);
        vec_t v;
        v.rst = r; v.enq = e; v.din = d; v.deq = q;
        v.exp_ready = er; v.exp_valid = dv; v.exp_dout = dout_exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int step, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0d expected=%0d", name, step, act, exp);
        end
    endtask

    task automatic apply(input bit r, input bit e, input bit [3:0] d, input bit q);
        @(negedge clk);
        rst = r; enq = e; din = d; deq = q;
        @(posedge clk);
        #1;
    endtask

    // Reference model state
    data_t mq[$];
    data_t hist[$];

    initial begin
        rst = 1'b1; enq = 1'b0; din = '0; deq = 1'b0;
        checks = 0; failures = 0;

        //    rst enq din deq | ready valid dout
        add(1, 0, 0, 0,   1, 0, 0);
        add(0, 1, 1, 0,   1, 1, 1);
        add(0, 1, 2, 0,   0, 1, 1);
        add(0, 1, 7, 0,   0, 1, 1);
        add(0, 0, 0, 1,   1, 1, 2);
        add(0, 0, 0, 1,   1, 0, stale(1));
        add(0, 1, 3, 0,   1, 1, 3);
        add(0, 1, 4, 1,   1, 1, 4);
        add(0, 0, 0, 1,   1, 0, stale(3));
        add(0, 0, 0, 1,   1, 0, stale(3));
        for (int v = 5; v <= 9; v++) begin
            add(0, 1, 4'(v), 0,   1, 1, 4'(v));
            add(0, 0, 0, 1,       1, 0, stale(4'(v - 1)));
        end
        add(0, 1, 10, 0,  1, 1, 10);
        add(0, 1, 11, 0,  0, 1, 10);
        add(1, 1, 12, 1,  1, 0, 0);
        add(0, 0, 0, 1,   1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].enq, vecs[i].din, vecs[i].deq);
            check("vec_enq_ready", i, int'(enq_ready), int'(vecs[i].exp_ready));
            check("vec_deq_valid", i, int'(deq_valid), int'(vecs[i].exp_valid));
            check("vec_dout",      i, int'(dout),      int'(vecs[i].exp_dout));
        end

        // Randomized traffic against the queue model
        apply(1, 0, 0, 0);
        mq.delete(); hist.delete();
        for (int c = 0; c < 600; c++) begin
            bit r, e, q;
            bit [3:0] d;
            int exp_d;
            r = ($urandom_range(0, 49) == 0);
            e = $urandom_range(0, 1) == 1;
            q = $urandom_range(0, 2) != 0;
            d = 4'($urandom);
            apply(r, e, d, q);
            if (r) begin
                mq.delete(); hist.delete();
            end else begin
                bit de, dd;
                de = e && (mq.size() < D);
                dd = q && (mq.size() > 0);
                if (dd) void'(mq.pop_front());
                if (de) begin
                    mq.push_back(d);
                    hist.push_back(d);
                    if (hist.size() > D) void'(hist.pop_front());
                end
            end
            if (mq.size() > 0)
                exp_d = int'(mq[0]);
            else if (hist.size() >= D)
                exp_d = int'(stale(hist[hist.size() - D]));
            else
                exp_d = 0;
            check("rnd_enq_ready", c, int'(enq_ready), int'(mq.size() < D));
            check("rnd_deq_valid", c, int'(deq_valid), int'(mq.size() > 0));
            check("rnd_dout",      c, int'(dout),      exp_d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
